mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch requester (IF) and the load/store requester driven by the EX/MEM pipeline register outputs (MEM).
- FSM arbiter with a registered memory-side request, a wait-state handshake and a registered response pulse.
- Stall outputs freeze the IF and EX/MEM stages while their accesses are pending.
- Data accesses have priority; a bounded starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 8, address width (matches 8-bit PC/branch target)
DATA_W, 32, data width
STARVE_MAX, 4, max consecutive data grants while if_req is pending before fetch is forced

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid with if_valid
if_valid  out  1  one-cycle fetch completion pulse
if_stall  out  1  if_req & ~if_valid (combinational)
mem_read  in  1  load request from EX/MEM
mem_write  in  1  store request from EX/MEM
mem_addr  in  ADDR_W  data address (ALU result low bits)
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, valid with mem_valid
mem_valid  out  1  one-cycle data completion pulse (loads and stores)
mem_stall  out  1  (mem_read|mem_write) & ~mem_valid (combinational)
ram_en  out  1  memory access request
ram_we  out  1  write enable
ram_addr  out  ADDR_W  memory address
ram_wdata  out  DATA_W  memory write data
ram_rdata  in  DATA_W  memory read data, valid when ram_ready=1
ram_ready  in  1  access completes on the edge where ram_en=1 and ram_ready=1

Behaviour:
- Reset (synchronous, active-high): state=IDLE, starve_cnt=0. ram_en, ram_we, ram_addr, ram_wdata, if_rdata, if_valid, mem_rdata and mem_valid are all 0.
- Reset mid-transaction abandons the access: ram_en=0 the next cycle, no valid pulse.
- States: IDLE, DATA, FETCH, RESP.
- IDLE arbitration:
  - data_req = mem_read|mem_write.
  - If data_req and !(if_req && starve_cnt==STARVE_MAX): go to DATA. Register ram_en=1, ram_we=mem_write, ram_addr=mem_addr, ram_wdata=mem_wdata.
  - Else if if_req: go to FETCH. Register ram_en=1, ram_we=0, ram_addr=if_addr.
  - Else stay in IDLE with ram_en=0.
- DATA/FETCH:
  - ram_en, ram_we, ram_addr and ram_wdata are held stable until the edge where ram_ready=1.
  - On that edge go to RESP and drop ram_en and ram_we to 0.
  - DATA: mem_valid<=1; for a load, mem_rdata<=ram_rdata.
  - FETCH: if_valid<=1, if_rdata<=ram_rdata.
- RESP: exactly one cycle, with the valid pulse high. New requests are ignored because the requester's signals still belong to the completed access. Return to IDLE unconditionally; valids clear.
- Latency: request sampled at edge N in IDLE. With zero wait states (ram_ready high in the first ram_en cycle), ram_ready is sampled at edge N+1 and valid is high during cycle N+1..N+2. Each wait state adds 1 cycle. Minimum issue interval is 3 cycles.
- mem_read and mem_write both high: treated as a store; mem_rdata is unchanged.
- Stores pulse mem_valid but leave mem_rdata unchanged.
- starve_cnt:
  - On a DATA grant with if_req high: increment, saturating at STARVE_MAX.
  - On a FETCH grant, or any IDLE cycle with if_req low: clear to 0.
- Requester inputs change mid-access (protocol violation): ignored, because the memory-side outputs are registered at grant time.
- Both stalls assert in the request cycle itself and clear in the valid cycle, so the pipeline advances on the edge ending the valid cycle.

Test Plan:
- Reset: hold reset 2 cycles with if_req=mem_read=1 -> all outputs 0 and ram_en stays 0; after reset deasserts, the data grant appears 1 cycle later.
- Load, zero wait: mem_read=1, mem_addr=0x10, ram_ready=1, ram_rdata=0xDEADBEEF -> ram_en=1/ram_we=0/ram_addr=0x10 for 1 cycle; mem_valid=1 for 1 cycle with mem_rdata=0xDEADBEEF; mem_stall high for 2 cycles.
- Store, 2 wait states: mem_write=1, mem_addr=0x24, mem_wdata=0x12345678, ram_ready low for 2 cycles -> ram_en=ram_we=1 with stable addr/data for 3 cycles; mem_valid pulses once; mem_rdata is unchanged.
- Contention: if_req and mem_read rise together, zero wait -> DATA granted first (mem_valid at cycle 2); FETCH granted next (ram_addr=if_addr at cycle 4, if_valid at cycle 5).
- Starvation, STARVE_MAX=4: if_req held high while mem_read is reasserted each IDLE -> exactly 4 DATA grants, then a FETCH grant; starve_cnt returns to 0 after it.
- Reset during FETCH wait state -> ram_en=0 next cycle, if_valid never pulses, state is IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the instruction-fetch
//   requester (IF) and the load/store requester (EX/MEM). Data accesses win
//   arbitration, but a saturating starvation counter forces a fetch grant
//   once STARVE_MAX data grants have been made while a fetch was waiting.
//   The memory-side request is registered at grant time and held until the
//   memory reports ready. Completion is a one-cycle registered valid pulse.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   if_req, if_addr                 fetch request (held until if_valid)
//   if_rdata, if_valid, if_stall    fetch response and stall
//   mem_read, mem_write             load / store request from EX/MEM
//   mem_addr, mem_wdata             data address and store data
//   mem_rdata, mem_valid, mem_stall data response and stall
//   ram_en, ram_we                  memory request and write enable
//   ram_addr, ram_wdata             memory address and write data
//   ram_rdata, ram_ready            memory read data and completion
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              mem_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             data_req;
  logic             starved;

  assign data_req = mem_read | mem_write;
  // A waiting fetch that has already been passed over STARVE_MAX times wins.
  assign starved  = if_req && (starve_cnt == CNT_W'(STARVE_MAX));

  // Stalls are combinational so they cover the request cycle itself and
  // drop in the valid cycle, letting the pipeline advance on the next edge.
  assign if_stall  = if_req & ~if_valid;
  assign mem_stall = data_req & ~mem_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      mem_rdata  <= '0;
      mem_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req && !starved) begin
            state     <= DATA;
            ram_en    <= 1'b1;
            ram_we    <= mem_write;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != CNT_W'(STARVE_MAX))
              starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (if_req) begin
            state      <= FETCH;
            ram_en     <= 1'b1;
            ram_we     <= 1'b0;
            ram_addr   <= if_addr;
            starve_cnt <= '0;
          end else begin
            ram_en     <= 1'b0;
            starve_cnt <= '0;
          end
        end

        // ram_we doubles as the load/store flag of the access in flight,
        // so a load is recognised by ram_we still being low here.
        DATA: begin
          if (ram_ready) begin
            state     <= RESP;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            mem_valid <= 1'b1;
            if (!ram_we)
              mem_rdata <= ram_rdata;
          end
        end

        FETCH: begin
          if (ram_ready) begin
            state    <= RESP;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            if_valid <= 1'b1;
            if_rdata <= ram_rdata;
          end
        end

        // Requester signals still describe the completed access here, so
        // nothing is arbitrated in this cycle.
        RESP: begin
          state     <= IDLE;
          if_valid  <= 1'b0;
          mem_valid <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter. Outputs are sampled
//   1 time unit after each rising edge; inputs are changed at the same point.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_stall;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  int compared;
  int mismatched;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .mem_stall(mem_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r_req, input logic w_req,
                               input logic [7:0] addr, input logic [31:0] wdata,
                               input logic f_req, input logic [7:0] faddr,
                               input logic ready, input logic [31:0] rdata);
    mem_read  = r_req;
    mem_write = w_req;
    mem_addr  = addr;
    mem_wdata = wdata;
    if_req    = f_req;
    if_addr   = faddr;
    ram_ready = ready;
    ram_rdata = rdata;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held two cycles with both requesters active.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 8'h02, 1'b0, 32'h0);
    tick();
    checkOutput("rst_ram_en_c1", ram_en, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_wdata", ram_wdata, 0);
    checkOutput("rst_if_valid", if_valid, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_mem_valid", mem_valid, 0);
    checkOutput("rst_mem_rdata", mem_rdata, 0);
    tick();
    checkOutput("rst_ram_en_c2", ram_en, 0);
    reset = 1'b0;
    if_req = 1'b0;
    tick();
    checkOutput("post_rst_grant_en", ram_en, 1);
    checkOutput("post_rst_grant_addr", ram_addr, 8'h01);
    ram_ready = 1'b1;
    ram_rdata = 32'h11111111;
    tick();
    checkOutput("post_rst_valid", mem_valid, 1);
    checkOutput("post_rst_rdata", mem_rdata, 32'h11111111);
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b0, 32'h0);
    tick();
    checkOutput("post_rst_valid_clr", mem_valid, 0);

    // Load with zero wait states.
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 8'h0, 1'b1, 32'hDEADBEEF);
    #1;
    checkOutput("ld_stall_req_cycle", mem_stall, 1);
    tick();
    checkOutput("ld_ram_en", ram_en, 1);
    checkOutput("ld_ram_we", ram_we, 0);
    checkOutput("ld_ram_addr", ram_addr, 8'h10);
    checkOutput("ld_stall_access", mem_stall, 1);
    checkOutput("ld_valid_early", mem_valid, 0);
    tick();
    checkOutput("ld_ram_en_drop", ram_en, 0);
    checkOutput("ld_valid", mem_valid, 1);
    checkOutput("ld_rdata", mem_rdata, 32'hDEADBEEF);
    checkOutput("ld_stall_clear", mem_stall, 0);
    mem_read = 1'b0;
    tick();
    checkOutput("ld_valid_clr", mem_valid, 0);

    // Store with two wait states; requester inputs wander mid-access.
    applyStimulus(1'b0, 1'b1, 8'h24, 32'h12345678, 1'b0, 8'h0, 1'b0, 32'hAAAAAAAA);
    tick();
    checkOutput("st_en_w0", ram_en, 1);
    checkOutput("st_we_w0", ram_we, 1);
    checkOutput("st_addr_w0", ram_addr, 8'h24);
    checkOutput("st_wdata_w0", ram_wdata, 32'h12345678);
    mem_addr  = 8'h99;
    mem_wdata = 32'h0;
    tick();
    checkOutput("st_en_w1", ram_en, 1);
    checkOutput("st_addr_w1", ram_addr, 8'h24);
    checkOutput("st_wdata_w1", ram_wdata, 32'h12345678);
    checkOutput("st_valid_w1", mem_valid, 0);
    tick();
    checkOutput("st_en_w2", ram_en, 1);
    checkOutput("st_we_w2", ram_we, 1);
    ram_ready = 1'b1;
    tick();
    checkOutput("st_valid", mem_valid, 1);
    checkOutput("st_rdata_kept", mem_rdata, 32'hDEADBEEF);
    checkOutput("st_en_drop", ram_en, 0);
    checkOutput("st_we_drop", ram_we, 0);
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b0, 32'h0);
    tick();
    checkOutput("st_valid_clr", mem_valid, 0);

    // Contention: data first, fetch next.
    applyStimulus(1'b1, 1'b0, 8'h30, 32'h0, 1'b1, 8'h40, 1'b1, 32'hCAFEF00D);
    #1;
    checkOutput("ct_if_stall_req", if_stall, 1);
    tick();
    checkOutput("ct_c1_addr", ram_addr, 8'h30);
    checkOutput("ct_c1_we", ram_we, 0);
    tick();
    checkOutput("ct_c2_mem_valid", mem_valid, 1);
    checkOutput("ct_c2_mem_rdata", mem_rdata, 32'hCAFEF00D);
    checkOutput("ct_c2_if_valid", if_valid, 0);
    checkOutput("ct_c2_if_stall", if_stall, 1);
    mem_read  = 1'b0;
    ram_rdata = 32'h0BADC0DE;
    tick();
    checkOutput("ct_c3_ram_en", ram_en, 0);
    tick();
    checkOutput("ct_c4_ram_en", ram_en, 1);
    checkOutput("ct_c4_addr", ram_addr, 8'h40);
    tick();
    checkOutput("ct_c5_if_valid", if_valid, 1);
    checkOutput("ct_c5_if_rdata", if_rdata, 32'h0BADC0DE);
    checkOutput("ct_c5_if_stall", if_stall, 0);
    if_req = 1'b0;
    tick();
    checkOutput("ct_if_valid_clr", if_valid, 0);
    tick();

    // Starvation: four data grants, then a forced fetch.
    applyStimulus(1'b1, 1'b0, 8'h60, 32'h0, 1'b1, 8'h50, 1'b1, 32'h5A5A5A5A);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput($sformatf("sv_grant%0d_addr", k), ram_addr, (k <= 4) ? 8'h60 : 8'h50);
      checkOutput($sformatf("sv_grant%0d_cnt", k), dut.starve_cnt, (k <= 4) ? k : 0);
      tick();
      checkOutput($sformatf("sv_grant%0d_mvalid", k), mem_valid, (k <= 4) ? 1 : 0);
      checkOutput($sformatf("sv_grant%0d_ivalid", k), if_valid, (k <= 4) ? 0 : 1);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b0, 32'h0);
    tick();

    // Read and write together act as a store.
    applyStimulus(1'b1, 1'b1, 8'h08, 32'h00000055, 1'b0, 8'h0, 1'b1, 32'h77777777);
    tick();
    checkOutput("rw_ram_we", ram_we, 1);
    checkOutput("rw_wdata", ram_wdata, 32'h00000055);
    tick();
    checkOutput("rw_valid", mem_valid, 1);
    checkOutput("rw_rdata_kept", mem_rdata, 32'h5A5A5A5A);
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b0, 32'h0);
    tick();

    // Reset during a fetch wait state.
    applyStimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 8'h70, 1'b0, 32'h99999999);
    tick();
    checkOutput("rf_en", ram_en, 1);
    checkOutput("rf_addr", ram_addr, 8'h70);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("rf_en_after_rst", ram_en, 0);
    checkOutput("rf_if_valid_rst", if_valid, 0);
    checkOutput("rf_state_idle", dut.state, 0);
    reset     = 1'b0;
    if_req    = 1'b0;
    ram_ready = 1'b1;
    tick();
    checkOutput("rf_if_valid_a", if_valid, 0);
    checkOutput("rf_en_a", ram_en, 0);
    tick();
    checkOutput("rf_if_valid_b", if_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
